// File: rtl/instr_mem_loader_if.sv
// Handshake and memory-write bundle between a host/boot link and the
// instruction memory loader. The loader drives the slave side.
//
// Byte handshake: a byte on byte_data is transferred on every rising clk
// edge where byte_valid and byte_ready are both 1; byte_valid may drop at any
// time, and byte_ready never depends combinationally on byte_valid.
interface instr_mem_loader_if #(
    parameter int LEN_W = 9
) ();
    logic             start;
    logic [LEN_W-1:0] length;
    logic             byte_valid;
    logic [7:0]       byte_data;
    logic             byte_ready;
    logic             mem_we;
    logic [31:0]      mem_addr;
    logic [31:0]      mem_wdata;
    logic             busy;
    logic             done;
    logic             error;
    logic             cpu_hold;
    logic [1:0]       dbg_state;   // loader FSM state, for observation only

    modport master (
        output start, length, byte_valid, byte_data,
        input  byte_ready, mem_we, mem_addr, mem_wdata,
        input  busy, done, error, cpu_hold, dbg_state
    );

    modport slave (
        input  start, length, byte_valid, byte_data,
        output byte_ready, mem_we, mem_addr, mem_wdata,
        output busy, done, error, cpu_hold, dbg_state
    );
endinterface

// File: rtl/instr_mem_loader.sv
// Instruction memory loader: packs a byte stream MSB-first into 32-bit words
// and writes them to consecutive word addresses from 0, holding the CPU in
// reset for the whole load. All outputs come straight from flops.
module instr_mem_loader #(
    parameter int MEM_SIZE = 256,
    parameter int LEN_W    = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    instr_mem_loader_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2,
        FINISH  = 2'd3
    } state_t;

    // One extra bit so a length above MEM_SIZE compares correctly even when
    // MEM_SIZE itself fills LEN_W.
    localparam logic [LEN_W:0] MAX_LEN = (LEN_W+1)'(MEM_SIZE);
    localparam int             PAD_W   = 30 - LEN_W;

    state_t           state_q;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] word_idx_q;
    logic [1:0]       byte_cnt_q;
    logic [23:0]      shift_q;      // first three bytes of the current word
    logic             byte_ready_q;
    logic             mem_we_q;
    logic [31:0]      mem_addr_q;
    logic [31:0]      mem_wdata_q;
    logic             busy_q;
    logic             done_q;
    logic             error_q;

    // Load sequencer: state, datapath and registered outputs in one place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            len_q        <= '0;
            word_idx_q   <= '0;
            byte_cnt_q   <= '0;
            shift_q      <= '0;
            byte_ready_q <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            // Pulse outputs default low; the branches below raise them.
            mem_we_q <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        if (bus.length == '0 || {1'b0, bus.length} > MAX_LEN) begin
                            error_q <= 1'b1;
                        end else begin
                            len_q        <= bus.length;
                            word_idx_q   <= '0;
                            byte_cnt_q   <= '0;
                            byte_ready_q <= 1'b1;
                            busy_q       <= 1'b1;
                            state_q      <= COLLECT;
                        end
                    end
                end
                COLLECT: begin
                    if (bus.byte_valid && byte_ready_q) begin
                        shift_q    <= {shift_q[15:0], bus.byte_data};
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (byte_cnt_q == 2'd3) begin
                            byte_ready_q <= 1'b0;
                            mem_we_q     <= 1'b1;
                            mem_addr_q   <= {{PAD_W{1'b0}}, word_idx_q, 2'b00};
                            mem_wdata_q  <= {shift_q, bus.byte_data};
                            state_q      <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    if (word_idx_q == len_q - LEN_W'(1)) begin
                        done_q  <= 1'b1;
                        state_q <= FINISH;
                    end else begin
                        word_idx_q   <= word_idx_q + LEN_W'(1);
                        byte_cnt_q   <= '0;
                        byte_ready_q <= 1'b1;
                        state_q      <= COLLECT;
                    end
                end
                FINISH: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.byte_ready = byte_ready_q;
    assign bus.mem_we     = mem_we_q;
    assign bus.mem_addr   = mem_addr_q;
    assign bus.mem_wdata  = mem_wdata_q;
    assign bus.busy       = busy_q;
    assign bus.cpu_hold   = busy_q;
    assign bus.done       = done_q;
    assign bus.error      = error_q;
    assign bus.dbg_state  = state_q;
endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader: stimulus pushes expected writes into
// a queue, a negedge monitor pops and compares every mem_we it sees.
module tb_instr_mem_loader;
  logic clk;
  logic rst;

  instr_mem_loader_if #(.LEN_W(9)) bus ();

  instr_mem_loader #(.MEM_SIZE(256), .LEN_W(9)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [63:0] exp_q[$];   // {addr, data} of each expected write
  int exp_done  = 0;
  int got_done  = 0;
  int exp_error = 0;
  int got_error = 0;
  int bytes_acc = 0;       // bytes accepted since the last write
  logic prev_we  = 1'b0;
  logic prev_err = 1'b0;
  logic hold_check = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst) begin
      prev_we    = 1'b0;
      prev_err   = 1'b0;
      hold_check = 1'b0;
    end else begin
      if (hold_check) begin
        check("idle_after_done", {62'd0, bus.cpu_hold, bus.busy}, 64'd0);
        hold_check = 1'b0;
      end
      if (bus.mem_we) begin
        check("write_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          logic [63:0] e;
          e = exp_q.pop_front();
          check("mem_addr", 64'(bus.mem_addr), 64'(e[63:32]));
          check("mem_wdata", 64'(bus.mem_wdata), 64'(e[31:0]));
        end
        check("addr_in_range", 64'(bus.mem_addr <= 32'h3FC && bus.mem_addr[1:0] == 2'b00), 64'd1);
        check("bytes_per_word", 64'(bytes_acc), 64'd4);
        check("ready_low_in_write", 64'(bus.byte_ready), 64'd0);
        bytes_acc = 0;
      end
      if (bus.done) begin
        got_done++;
        check("done_after_last_write", 64'(prev_we), 64'd1);
        check("queue_drained_at_done", 64'(exp_q.size()), 64'd0);
        hold_check = 1'b1;
      end
      if (bus.error) begin
        got_error++;
        check("error_one_cycle", 64'(prev_err), 64'd0);
        check("error_idle", {62'd0, bus.busy, bus.cpu_hold}, 64'd0);
      end
      prev_we  = bus.mem_we;
      prev_err = bus.error;
    end
  end

  // driver tasks: all start and end just after a falling edge
  task automatic send_byte(input logic [7:0] b, input int gap);
    int t;
    if (gap > 0) begin
      bus.byte_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
    bus.byte_valid = 1'b1;
    bus.byte_data  = b;
    t = 0;
    while (!bus.byte_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      check("byte_ready_timeout", 64'(t), 64'd0);
    end else begin
      @(posedge clk);
      bytes_acc++;
      @(negedge clk);
    end
    bus.byte_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w, input logic gaps);
    for (int k = 3; k >= 0; k--)
      send_byte(w[k*8 +: 8], gaps ? int'($urandom_range(0, 3)) : 0);
  endtask

  task automatic expect_write(input int idx, input logic [31:0] w);
    logic [31:0] a;
    a = 32'(idx) << 2;
    exp_q.push_back({a, w});
  endtask

  task automatic issue_start(input logic [8:0] len, input logic illegal);
    bus.start  = 1'b1;
    bus.length = len;
    @(negedge clk);
    bus.start = 1'b0;
    if (illegal) begin
      exp_error++;
      check("error_pulse", 64'(bus.error), 64'd1);
      check("illegal_no_busy", {62'd0, bus.busy, bus.cpu_hold}, 64'd0);
    end else begin
      check("start_to_ready", {61'd0, bus.byte_ready, bus.busy, bus.cpu_hold}, 64'd7);
    end
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while (got_done < exp_done && t < 3000) begin
      @(negedge clk);
      t++;
    end
    check("done_count", 64'(got_done), 64'(exp_done));
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [31:0] w;
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.length     = '0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {bus.byte_ready, bus.mem_we, bus.busy, bus.done, bus.error, bus.cpu_hold,
           bus.dbg_state, 56'd0}, 64'd0);
    check("reset_addr_data", {bus.mem_addr, bus.mem_wdata}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // basic load, back to back
    expect_write(0, 32'h8C010004);
    expect_write(1, 32'hAC020008);
    exp_done++;
    issue_start(9'd2, 1'b0);
    send_word(32'h8C010004, 1'b0);
    send_word(32'hAC020008, 1'b0);
    wait_done();

    // gaps between bytes
    expect_write(0, 32'h12345678);
    exp_done++;
    issue_start(9'd1, 1'b0);
    send_word(32'h12345678, 1'b1);
    wait_done();

    // illegal lengths
    issue_start(9'd0, 1'b1);
    repeat (3) @(negedge clk);
    issue_start(9'd257, 1'b1);
    repeat (3) @(negedge clk);
    check("illegal_error_count", 64'(got_error), 64'(exp_error));

    // full depth
    for (int i = 0; i < 256; i++) expect_write(i, 32'(i));
    exp_done++;
    issue_start(9'd256, 1'b0);
    for (int i = 0; i < 256; i++) send_word(32'(i), 1'b0);
    wait_done();

    // reset in the middle of a load
    expect_write(0, 32'hDEADBEEF);
    issue_start(9'd4, 1'b0);
    send_word(32'hDEADBEEF, 1'b0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    rst = 1'b1;
    #1;
    check("midload_reset_outputs",
          {bus.byte_ready, bus.mem_we, bus.busy, bus.done, bus.error, bus.cpu_hold, 58'd0}, 64'd0);
    check("midload_reset_state", 64'(bus.dbg_state), 64'd0);
    bytes_acc = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("no_write_after_reset", 64'(exp_q.size()), 64'd0);
    expect_write(0, 32'hCAFE0001);
    exp_done++;
    issue_start(9'd1, 1'b0);
    send_word(32'hCAFE0001, 1'b0);
    wait_done();

    // start while busy is ignored
    expect_write(0, 32'h01020304);
    expect_write(1, 32'h05060708);
    exp_done++;
    issue_start(9'd2, 1'b0);
    send_byte(8'h01, 0);
    send_byte(8'h02, 0);
    bus.start  = 1'b1;
    bus.length = 9'd1;
    @(negedge clk);
    bus.start = 1'b0;
    check("busy_start_no_error", 64'(bus.error), 64'd0);
    w = 32'h05060708;
    send_byte(8'h03, 0);
    send_byte(8'h04, 0);
    send_word(w, 1'b0);
    wait_done();

    check("final_queue_empty", 64'(exp_q.size()), 64'd0);
    check("final_done_count", 64'(got_done), 64'(exp_done));
    check("final_error_count", 64'(got_error), 64'(exp_error));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
